zn_csa: RTL and testbench
=========================

// Module: zn_csa
// PURPOSE
//  8-bit carry-select adder with registered outputs: sum/c_out = a + b + c_in.
//  Leaf arithmetic block for the datapath; pure adder, no flags or overflow logic.
//  Low block ripples from c_in; upper blocks pre-compute both carry-in cases and
//  select with the incoming block carry, so worst path is one block ripple plus muxes.
// PARAMETERS
//  WIDTH  8  operand/sum width in bits; must be a multiple of BLOCK
//  BLOCK  4  bits per carry-select block (8/4 = two blocks)
// PORTS
//  clk    in   1      single clock; all state updates on rising edge
//  rst    in   1      synchronous, active-high reset
//  a      in   WIDTH  operand A, unsigned
//  b      in   WIDTH  operand B, unsigned
//  c_in   in   1      carry into bit 0
//  sum    out  WIDTH  registered (a + b + c_in) mod 2^WIDTH
//  c_out  out  1      registered carry out of bit WIDTH-1
// BEHAVIOUR
//  - One clock; sync active-high reset; no async paths to outputs.
//  - Reset: rst=1 at a rising edge -> sum=0, c_out=0 at that edge; rst dominates inputs.
//  - Latency 1: inputs sampled at edge N -> {c_out,sum} valid after edge N; no handshake,
//    new result every cycle, fully pipelined throughput of 1/cycle.
//  - Arithmetic: {c_out,sum} = a + b + c_in, WIDTH+1-bit unsigned result, no truncation of carry.
//  - Block 0 (bits BLOCK-1:0): ripple-carry full adders from c_in; yields carry k0.
//  - Block i>0: two ripple adders, carry-in 0 and carry-in 1; sum and carry muxed by
//    carry out of block i-1. Final block's selected carry = c_out.
//  - Full adder: s = x^y^ci; co = x&y | ci&(x^y).
//  - Wrap-around: 8'hFF+8'h01+0 -> sum 00, c_out 1; carry must propagate across block edge.
//  - Reset released mid-stream: first result appears after first non-reset edge.
//  - X/Z on inputs not required to be handled.
// TESTING
//  1. rst=1 one edge, a=FF b=FF c_in=1 -> sum=00, c_out=0 (reset wins).
//  2. rst=0, a=FF b=FF c_in=1 -> next edge sum=FF, c_out=1.
//  3. a=0F b=01 c_in=0 -> sum=10, c_out=0 (block-boundary carry selects upper sum).
//  4. a=FF b=00 c_in=1 -> sum=00, c_out=1 (full-length propagate).
//  5. a=00 b=00 c_in=0 -> sum=00, c_out=0; then a=3C b=A5 c_in=0 -> sum=E1, c_out=0.
//  6. Exhaustive 2^17 a/b/c_in sweep, back-to-back each cycle -> matches a+b+c_in one cycle later.

Source files
------------

// File: rtl/zn_csa_if.sv
// Operand/result bundle for the zn_csa carry-select adder.
// The master drives operands and carry-in; the slave returns the registered sum.
interface zn_csa_if #(
  parameter int WIDTH = 8
);
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             c_in;
  logic [WIDTH-1:0] sum;
  logic             c_out;

  modport master (output a, b, c_in, input  sum, c_out);
  modport slave  (input  a, b, c_in, output sum, c_out);
endinterface

// File: rtl/zn_csa.sv
// Registered carry-select adder: {c_out,sum} = a + b + c_in, one cycle of latency.
// Block 0 ripples from c_in; each upper block precomputes both carry-in cases and muxes.
module zn_csa #(
  parameter int WIDTH = 8,
  parameter int BLOCK = 4
) (
  input  logic     clk,
  input  logic     rst,
  zn_csa_if.slave  bus
);

  localparam int NBLK = WIDTH / BLOCK;

  logic [WIDTH-1:0] sum_d, sum_q;
  logic             c_out_d, c_out_q;

  // Block-local scratch used while walking the blocks in the loop below.
  logic             blk_c;
  logic [BLOCK:0]   r0, r1, r_sel;

  // Ripple-carry chain of full adders; returns {carry_out, sum}.
  function automatic logic [BLOCK:0] ripple(input logic [BLOCK-1:0] x,
                                            input logic [BLOCK-1:0] y,
                                            input logic             ci);
    logic             c;
    logic [BLOCK-1:0] s;
    c = ci;
    s = '0;
    for (int j = 0; j < BLOCK; j++) begin
      s[j] = x[j] ^ y[j] ^ c;
      c    = (x[j] & y[j]) | (c & (x[j] ^ y[j]));
    end
    return {c, s};
  endfunction

  always_comb begin
    // NOTE: every variable gets a default before any branch, so no path leaves
    // a value held and no latch is inferred.
    sum_d   = '0;
    c_out_d = 1'b0;
    blk_c   = bus.c_in;
    r0      = '0;
    r1      = '0;
    r_sel   = '0;
    for (int i = 0; i < NBLK; i++) begin
      if (i == 0) begin
        r_sel = ripple(bus.a[0 +: BLOCK], bus.b[0 +: BLOCK], bus.c_in);
      end else begin
        // Both candidate results are ready before the lower block's carry arrives.
        r0    = ripple(bus.a[i*BLOCK +: BLOCK], bus.b[i*BLOCK +: BLOCK], 1'b0);
        r1    = ripple(bus.a[i*BLOCK +: BLOCK], bus.b[i*BLOCK +: BLOCK], 1'b1);
        r_sel = blk_c ? r1 : r0;
      end
      sum_d[i*BLOCK +: BLOCK] = r_sel[BLOCK-1:0];
      blk_c                   = r_sel[BLOCK];
    end
    c_out_d = blk_c;
  end

  always_ff @(posedge clk) begin
    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    if (rst) begin
      sum_q   <= '0;
      c_out_q <= 1'b0;
    end else begin
      sum_q   <= sum_d;
      c_out_q <= c_out_d;
    end
  end

  assign bus.sum   = sum_q;
  assign bus.c_out = c_out_q;

endmodule

// File: tb/tb_zn_csa.sv
// Self-checking bench for zn_csa: directed vector table, reset-in-stream sequence,
// and a randomized back-to-back run against an arithmetic reference model.
module tb_zn_csa;

  localparam int WIDTH = 8;

  logic clk;
  logic rst;

  zn_csa_if #(.WIDTH(WIDTH)) bus ();

  zn_csa #(.WIDTH(WIDTH), .BLOCK(4)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic             rst;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             c_in;
    logic [WIDTH-1:0] exp_sum;
    logic             exp_cout;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [WIDTH:0] got, input logic [WIDTH:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got {c_out,sum}=%h expected %h", name, got, exp);
    end
  endtask

  // Reference: plain unsigned addition into a WIDTH+1-bit result; reset forces zero.
  function automatic logic [WIDTH:0] model(input logic r, input logic [WIDTH-1:0] a,
                                           input logic [WIDTH-1:0] b, input logic ci);
    int unsigned s;
    if (r) return '0;
    s = int'(a) + int'(b) + int'(ci);
    return s[WIDTH:0];
  endfunction

  // Drive inputs, let one rising edge pass, sample 1 time unit later.
  task automatic step(input logic r, input logic [WIDTH-1:0] a,
                      input logic [WIDTH-1:0] b, input logic ci);
    rst      = r;
    bus.a    = a;
    bus.b    = b;
    bus.c_in = ci;
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [WIDTH-1:0] ra, rb;
    logic             rc, rr;

    rst = 1'b1; bus.a = '0; bus.b = '0; bus.c_in = 1'b0;
    @(posedge clk); #1;
    check("reset_state", {bus.c_out, bus.sum}, '0);

    // Directed vectors: reset dominance, block-boundary carries, wrap-around.
    vecs.push_back('{1'b1, 8'hFF, 8'hFF, 1'b1, 8'h00, 1'b0});
    vecs.push_back('{1'b0, 8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1});
    vecs.push_back('{1'b0, 8'h0F, 8'h01, 1'b0, 8'h10, 1'b0});
    vecs.push_back('{1'b0, 8'hFF, 8'h00, 1'b1, 8'h00, 1'b1});
    vecs.push_back('{1'b0, 8'h00, 8'h00, 1'b0, 8'h00, 1'b0});
    vecs.push_back('{1'b0, 8'h3C, 8'hA5, 1'b0, 8'hE1, 1'b0});
    vecs.push_back('{1'b0, 8'hFF, 8'h01, 1'b0, 8'h00, 1'b1});
    vecs.push_back('{1'b0, 8'h0F, 8'h00, 1'b1, 8'h10, 1'b0});
    vecs.push_back('{1'b0, 8'h80, 8'h80, 1'b0, 8'h00, 1'b1});
    vecs.push_back('{1'b0, 8'h07, 8'h08, 1'b1, 8'h10, 1'b0});
    vecs.push_back('{1'b0, 8'hF0, 8'h0F, 1'b0, 8'hFF, 1'b0});
    vecs.push_back('{1'b0, 8'hF0, 8'h0F, 1'b1, 8'h00, 1'b1});
    vecs.push_back('{1'b0, 8'h7F, 8'h7F, 1'b1, 8'hFF, 1'b0});

    foreach (vecs[i]) begin
      step(vecs[i].rst, vecs[i].a, vecs[i].b, vecs[i].c_in);
      check($sformatf("vec%0d", i), {bus.c_out, bus.sum}, {vecs[i].exp_cout, vecs[i].exp_sum});
    end

    // Reset asserted mid-stream wins, then first result follows first non-reset edge.
    step(1'b0, 8'hC8, 8'h64, 1'b1);
    check("pre_reset", {bus.c_out, bus.sum}, 9'h12D);
    step(1'b1, 8'hAA, 8'h55, 1'b1);
    check("mid_reset_1", {bus.c_out, bus.sum}, 9'h000);
    step(1'b1, 8'h12, 8'h34, 1'b0);
    check("mid_reset_2", {bus.c_out, bus.sum}, 9'h000);
    step(1'b0, 8'h12, 8'h34, 1'b0);
    check("post_reset", {bus.c_out, bus.sum}, 9'h046);

    // Carry into the upper block from every low-nibble pattern with c_in.
    for (int lo = 0; lo < 16; lo++) begin
      ra = 8'(lo) | 8'h50;
      rb = 8'(15 - lo) | 8'h20;
      step(1'b0, ra, rb, 1'b1);
      check($sformatf("nibble_prop%0d", lo), {bus.c_out, bus.sum}, model(1'b0, ra, rb, 1'b1));
    end

    // Randomized back-to-back stream with occasional reset pulses.
    for (int n = 0; n < 4000; n++) begin
      ra = 8'($urandom);
      rb = 8'($urandom);
      rc = 1'($urandom);
      rr = ($urandom_range(0, 63) == 0);
      step(rr, ra, rb, rc);
      check("random", {bus.c_out, bus.sum}, model(rr, ra, rb, rc));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
